// File: rtl/csr_reg.sv
// Machine-mode CSR file: mstatus/misa/mie/mtvec/mscratch/mepc/mcause/mip/mhartid + optional cycle counter.
// Latency: reads are combinational from registered state (no write bypass); writes, traps and mret commit at the next edge.
// Backpressure: none; every request is accepted in its cycle. Optional 64-bit mcycle counter is enabled by CSR_CYCLE_EN.
module csr_reg #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MHARTID   = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rdata_o,
    input  logic        csr_we_i,
    input  logic [11:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic        mret_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_global_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    // Only the machine software/timer/external enables are implemented in mie.
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
    // Trap vector and return address are always word aligned.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // mstatus is kept as its two live bits; MPP is hardwired to machine mode.
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
`ifdef CSR_CYCLE_EN
    logic [63:0] mcycle_q,   mcycle_d;
`endif

    logic [31:0] mstatus_rd;
    logic        hw_owns_trap_state;
    logic        wr_mstatus;
    logic        wr_mie;
    logic        wr_mtvec;
    logic        wr_mscratch;
    logic        wr_mepc;
    logic        wr_mcause;
`ifdef CSR_CYCLE_EN
    logic        wr_mcycle;
    logic        wr_mcycleh;
`endif

    // A trap or mret owns mstatus/mepc/mcause for the cycle, so software writes to them are dropped.
    assign hw_owns_trap_state = trap_i | mret_i;

    // Software write strobes per CSR; writes to read-only or unmapped addresses decode to nothing.
    always_comb begin
        wr_mstatus  = csr_we_i && (csr_waddr_i == ADDR_MSTATUS) && !hw_owns_trap_state;
        wr_mie      = csr_we_i && (csr_waddr_i == ADDR_MIE);
        wr_mtvec    = csr_we_i && (csr_waddr_i == ADDR_MTVEC);
        wr_mscratch = csr_we_i && (csr_waddr_i == ADDR_MSCRATCH);
        wr_mepc     = csr_we_i && (csr_waddr_i == ADDR_MEPC)   && !hw_owns_trap_state;
        wr_mcause   = csr_we_i && (csr_waddr_i == ADDR_MCAUSE) && !hw_owns_trap_state;
`ifdef CSR_CYCLE_EN
        wr_mcycle   = csr_we_i && (csr_waddr_i == ADDR_MCYCLE);
        wr_mcycleh  = csr_we_i && (csr_waddr_i == ADDR_MCYCLEH);
`endif
    end

    // Next-state for mstatus: trap beats mret beats software write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        if (trap_i) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie_d  = csr_wdata_i[3];
            mstatus_mpie_d = csr_wdata_i[7];
        end
    end

    // Next-state for trap bookkeeping: a trap captures PC and cause; mret leaves them alone.
    always_comb begin
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (trap_i) begin
            mepc_d   = trap_pc_i & ALIGN_MASK;
            mcause_d = trap_cause_i;
        end else if (wr_mepc) begin
            mepc_d   = csr_wdata_i & ALIGN_MASK;
        end else if (wr_mcause) begin
            mcause_d = csr_wdata_i;
        end
    end

    // Next-state for plain software CSRs; these commit even in trap/mret cycles.
    always_comb begin
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        if (wr_mie) begin
            mie_d = csr_wdata_i & MIE_MASK;
        end
        if (wr_mtvec) begin
            mtvec_d = csr_wdata_i & ALIGN_MASK;
        end
        if (wr_mscratch) begin
            mscratch_d = csr_wdata_i;
        end
    end

`ifdef CSR_CYCLE_EN
    // Cycle counter: a software write to either half replaces it and suppresses that cycle's increment.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (wr_mcycle) begin
            mcycle_d = {mcycle_q[63:32], csr_wdata_i};
        end else if (wr_mcycleh) begin
            mcycle_d = {csr_wdata_i, mcycle_q[31:0]};
        end
    end
`endif

    // State registers with synchronous reset; MPP needs no storage since it always reads 2'b11.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= MTVEC_RST & ALIGN_MASK;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

`ifdef CSR_CYCLE_EN
    // Counter register kept separate so the default build carries no counter flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle_q <= 64'h0;
        end else begin
            mcycle_q <= mcycle_d;
        end
    end
`endif

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

    // Read mux straight off the registers; unmapped addresses read zero.
    always_comb begin
        csr_rdata_o = 32'h0;
        case (csr_raddr_i)
            ADDR_MSTATUS:  csr_rdata_o = mstatus_rd;
            ADDR_MISA:     csr_rdata_o = MISA_VAL;
            ADDR_MIE:      csr_rdata_o = mie_q;
            ADDR_MTVEC:    csr_rdata_o = mtvec_q;
            ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
            ADDR_MEPC:     csr_rdata_o = mepc_q;
            ADDR_MCAUSE:   csr_rdata_o = mcause_q;
            ADDR_MIP:      csr_rdata_o = 32'h0;
`ifdef CSR_CYCLE_EN
            ADDR_MCYCLE:   csr_rdata_o = mcycle_q[31:0];
            ADDR_MCYCLEH:  csr_rdata_o = mcycle_q[63:32];
`else
            ADDR_MCYCLE:   csr_rdata_o = 32'h0;
            ADDR_MCYCLEH:  csr_rdata_o = 32'h0;
`endif
            ADDR_MHARTID:  csr_rdata_o = MHARTID;
            default:       csr_rdata_o = 32'h0;
        endcase
    end

    assign mtvec_o      = mtvec_q;
    assign mepc_o       = mepc_q;
    assign mie_global_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_reg.sv
// Scoreboard bench for csr_reg: stimulus queues expected values, a negedge monitor pops and compares.
// Expected values are hand-computed constants; counter expectations follow the CSR_CYCLE_EN build.
// Every wait is bounded by a global watchdog.
module tb_csr_reg;

    localparam logic [31:0] P_MTVEC_RST = 32'h0000_1003;
    localparam logic [31:0] P_MHARTID   = 32'h0000_0005;
    localparam logic [31:0] P_MISA      = 32'h4000_0100;
`ifdef CSR_CYCLE_EN
    localparam bit CYC = 1'b1;
`else
    localparam bit CYC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] cause;
    logic [31:0] tpc;
    logic        mret;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_g;

    int errors = 0;
    int checks = 0;

    // Scoreboard: parallel queues of check name, output selector and expected value.
    string       name_q[$];
    int          sel_q[$];
    logic [31:0] val_q[$];

    csr_reg #(
        .MTVEC_RST(P_MTVEC_RST),
        .MHARTID  (P_MHARTID),
        .MISA_VAL (P_MISA)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .csr_raddr_i  (raddr),
        .csr_rdata_o  (rdata),
        .csr_we_i     (we),
        .csr_waddr_i  (waddr),
        .csr_wdata_i  (wdata),
        .trap_i       (trap),
        .trap_cause_i (cause),
        .trap_pc_i    (tpc),
        .mret_i       (mret),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .mie_global_o (mie_g)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: on every falling edge drain all queued expectations against the selected output.
    string       m_name;
    int          m_sel;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (name_q.size() > 0) begin
            m_name = name_q.pop_front();
            m_sel  = sel_q.pop_front();
            m_exp  = val_q.pop_front();
            case (m_sel)
                0:       m_act = rdata;
                1:       m_act = mtvec_o;
                2:       m_act = mepc_o;
                default: m_act = {31'b0, mie_g};
            endcase
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
            end
        end
    end

    task automatic push(input string n, input int s, input logic [31:0] v);
        name_q.push_back(n);
        sel_q.push_back(s);
        val_q.push_back(v);
    endtask

    // Advance one clock edge, then drop all single-cycle strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        we   = 1'b0;
        trap = 1'b0;
        mret = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        cyc();
    endtask

    // Read check: present the address and let the monitor sample it at the next falling edge.
    task automatic chk_rd(input string n, input logic [11:0] a, input logic [31:0] v);
        raddr = a;
        push(n, 0, v);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; raddr = 12'h300; we = 1'b0; waddr = 12'h0; wdata = 32'h0;
        trap = 1'b0; cause = 32'h0; tpc = 32'h0; mret = 1'b0;
        @(posedge clk);
        cyc();

        // Reset state.
        push("rst_mtvec_o", 1, 32'h0000_1000);
        push("rst_mepc_o", 2, 32'h0);
        push("rst_mie_global", 3, 32'h0);
        chk_rd("rst_mstatus", 12'h300, 32'h0000_1800);
        chk_rd("rst_mie", 12'h304, 32'h0);
        chk_rd("misa", 12'h301, P_MISA);
        chk_rd("mip", 12'h344, 32'h0);

        // mtvec write: same-cycle read shows old value, next cycle the aligned new value.
        @(posedge clk); #1;
        we = 1'b1; waddr = 12'h305; wdata = 32'h8000_0103; raddr = 12'h305;
        push("mtvec_same_cycle", 0, 32'h0000_1000);
        cyc();
        push("mtvec_o_new", 1, 32'h8000_0100);
        chk_rd("mtvec_new", 12'h305, 32'h8000_0100);

        // mie keeps only bits 3, 7, 11.
        wr(12'h304, 32'hFFFF_FFFF);
        chk_rd("mie_mask", 12'h304, 32'h0000_0888);

        // mstatus masking, then trap.
        wr(12'h300, 32'hFFFF_FFFF);
        chk_rd("mstatus_mask", 12'h300, 32'h0000_1888);
        wr(12'h300, 32'h0000_0008);
        push("mie_set", 3, 32'h1);
        chk_rd("mstatus_mie", 12'h300, 32'h0000_1808);
        trap = 1'b1; cause = 32'h8000_0007; tpc = 32'h0000_0123;
        cyc();
        push("trap_mepc_o", 2, 32'h0000_0120);
        push("trap_mie_global", 3, 32'h0);
        chk_rd("trap_mepc", 12'h341, 32'h0000_0120);
        chk_rd("trap_mcause", 12'h342, 32'h8000_0007);
        chk_rd("trap_mstatus", 12'h300, 32'h0000_1880);

        // mret restores MIE from MPIE and sets MPIE.
        mret = 1'b1;
        cyc();
        push("mret_mie_global", 3, 32'h1);
        chk_rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // trap + mret + mstatus write together: trap only.
        trap = 1'b1; mret = 1'b1; cause = 32'h0000_000B; tpc = 32'h0000_0207;
        we = 1'b1; waddr = 12'h300; wdata = 32'hFFFF_FFFF;
        cyc();
        push("combo_mie_global", 3, 32'h0);
        push("combo_mepc_o", 2, 32'h0000_0204);
        chk_rd("combo_mstatus", 12'h300, 32'h0000_1880);
        chk_rd("combo_mcause", 12'h342, 32'h0000_000B);

        // mret with an mepc write: the write is dropped.
        mret = 1'b1; we = 1'b1; waddr = 12'h341; wdata = 32'h0000_0FFF;
        cyc();
        push("mret_drop_mepc_o", 2, 32'h0000_0204);
        chk_rd("mret_drop_mstatus", 12'h300, 32'h0000_1888);

        // Trap with an mscratch write: the unrelated CSR still commits.
        trap = 1'b1; cause = 32'h0000_0002; tpc = 32'h0000_0400;
        we = 1'b1; waddr = 12'h340; wdata = 32'hCAFE_F00D;
        cyc();
        chk_rd("trap_keep_mscratch", 12'h340, 32'hCAFE_F00D);
        chk_rd("trap2_mepc", 12'h341, 32'h0000_0400);

        // Cycle counter carry, and no increment in a write cycle.
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0000_0000);
        chk_rd("mcycle_pre", 12'hB00, CYC ? 32'hFFFF_FFFF : 32'h0);
        chk_rd("mcycleh_carry", 12'hB80, CYC ? 32'h0000_0001 : 32'h0);
        chk_rd("mcycle_after", 12'hB00, CYC ? 32'h0000_0001 : 32'h0);

        // 64-bit wrap.
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        chk_rd("mcycleh_full", 12'hB80, CYC ? 32'hFFFF_FFFF : 32'h0);
        chk_rd("mcycleh_wrap", 12'hB80, 32'h0);
        chk_rd("mcycle_wrap", 12'hB00, CYC ? 32'h0000_0001 : 32'h0);

        // Read-only and unmapped addresses.
        wr(12'hF14, 32'h1234_5678);
        chk_rd("mhartid_ro", 12'hF14, P_MHARTID);
        wr(12'h7C0, 32'h1234_5678);
        chk_rd("unmapped", 12'h7C0, 32'h0);

        // Mid-run reset clears everything back to reset values.
        wr(12'h340, 32'hDEAD_BEEF);
        chk_rd("mscratch_set", 12'h340, 32'hDEAD_BEEF);
        rst = 1'b1;
        cyc();
        push("rst2_mtvec_o", 1, 32'h0000_1000);
        push("rst2_mepc_o", 2, 32'h0);
        push("rst2_mie_global", 3, 32'h0);
        chk_rd("rst2_mscratch", 12'h340, 32'h0);
        chk_rd("rst2_mstatus", 12'h300, 32'h0000_1800);
        chk_rd("rst2_mie", 12'h304, 32'h0);

        @(negedge clk);
        #1;
        checks++;
        if (name_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", name_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
